// File: rtl/fpu_addsub_seq.sv
// Multi-cycle IEEE-754 adder/subtractor, parametrised on exponent/fraction width.
// Round-to-nearest-even, denormals flushed to zero, valid/ready on both sides.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | in_ready high, waiting for an operation
// S_UNPACK | split fields, flush denormals, resolve NaN/inf/zero specials
// S_ALIGN  | order by magnitude, right-shift smaller mantissa with G/R/S
// S_ADD    | add or subtract aligned magnitudes, carry kept
// S_NORM   | carry right-shift or leading-zero left-shift, underflow flush
// S_PACK   | round to nearest even, overflow to inf, load result/flags
// S_DONE   | raise out_valid, hold result until out_ready
module fpu_addsub_seq #(
  parameter int bitness   = 64,
  parameter int exp_bits  = 11,
  parameter int frac_bits = 52
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [bitness-1:0] a,
  input  logic [bitness-1:0] b,
  input  logic               op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [bitness-1:0] result,
  output logic [3:0]         flags
);

  localparam int man_w = frac_bits + 1;
  localparam int wide  = man_w + 3;
  localparam int ew    = exp_bits + 2;
  localparam logic [exp_bits-1:0] exp_ones  = '1;
  localparam logic [exp_bits-1:0] sat_shift = exp_bits'(frac_bits + 3);
  localparam logic signed [ew-1:0] exp_max  = {2'b00, exp_ones};
  localparam logic [bitness-1:0] qnan = {1'b0, exp_ones, 1'b1, {(frac_bits-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_PACK, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [bitness-1:0]      a_q, b_q;
  logic                    op_q;
  logic                    sa_q, sb_q;
  logic [exp_bits-1:0]     ea_q, eb_q;
  logic [man_w-1:0]        ma_q, mb_q;
  logic                    spec_q;
  logic [bitness-1:0]      spec_res_q;
  logic [3:0]              spec_flags_q;
  logic                    al_sign_q, al_sub_q;
  logic [exp_bits-1:0]     al_exp_q;
  logic [wide-1:0]         big_q, small_q;
  logic [wide:0]           sum_q;
  logic                    sum_sign_q;
  logic [exp_bits-1:0]     sum_exp_q;
  logic [wide-1:0]         nrm_q;
  logic signed [ew-1:0]    nexp_q;
  logic                    nsign_q, zero_q, uf_q;

  // unpack
  logic                sa_d, sb_d, spec_d;
  logic [exp_bits-1:0] ea_d, eb_d;
  logic [man_w-1:0]    ma_d, mb_d;
  logic [bitness-1:0]  spec_res_d;
  logic [3:0]          spec_flags_d;
  logic                a_inf, b_inf, a_nan, b_nan, a_zero, b_zero;

  always_comb begin
    sa_d   = a_q[bitness-1];
    sb_d   = b_q[bitness-1] ^ op_q;
    ea_d   = a_q[bitness-2 -: exp_bits];
    eb_d   = b_q[bitness-2 -: exp_bits];
    a_zero = (ea_d == '0);
    b_zero = (eb_d == '0);
    a_inf  = (ea_d == exp_ones) && (a_q[frac_bits-1:0] == '0);
    b_inf  = (eb_d == exp_ones) && (b_q[frac_bits-1:0] == '0);
    a_nan  = (ea_d == exp_ones) && (a_q[frac_bits-1:0] != '0);
    b_nan  = (eb_d == exp_ones) && (b_q[frac_bits-1:0] != '0);
    ma_d   = a_zero ? '0 : {1'b1, a_q[frac_bits-1:0]};
    mb_d   = b_zero ? '0 : {1'b1, b_q[frac_bits-1:0]};
    spec_d       = 1'b1;
    spec_res_d   = '0;
    spec_flags_d = '0;
    if (a_nan || b_nan) begin
      spec_res_d = qnan;
    end else if (a_inf && b_inf && (sa_d != sb_d)) begin
      spec_res_d   = qnan;
      spec_flags_d = 4'b1000;
    end else if (a_inf) begin
      spec_res_d = {sa_d, exp_ones, {frac_bits{1'b0}}};
    end else if (b_inf) begin
      spec_res_d = {sb_d, exp_ones, {frac_bits{1'b0}}};
    end else if (a_zero && b_zero) begin
      spec_res_d = {sa_d & sb_d, {(bitness-1){1'b0}}};
    end else begin
      spec_d = 1'b0;
    end
  end

  // align
  logic                a_big;
  logic                al_sign_d;
  logic [exp_bits-1:0] e_big, e_small, diff;
  logic [man_w-1:0]    m_big, m_small;
  logic [wide-1:0]     ext, shifted, lost_mask, small_d;

  always_comb begin
    a_big     = {ea_q, ma_q} >= {eb_q, mb_q};
    e_big     = a_big ? ea_q : eb_q;
    e_small   = a_big ? eb_q : ea_q;
    m_big     = a_big ? ma_q : mb_q;
    m_small   = a_big ? mb_q : ma_q;
    al_sign_d = a_big ? sa_q : sb_q;
    diff      = e_big - e_small;
    ext       = {m_small, 3'b000};
    shifted   = ext >> diff;
    lost_mask = ~({wide{1'b1}} << diff);
    if (diff >= sat_shift)
      small_d = {{(wide-1){1'b0}}, |m_small};
    else
      small_d = {shifted[wide-1:1], shifted[0] | (|(ext & lost_mask))};
  end

  // add: big_q >= small_q always, so the difference never goes negative
  logic [wide:0] sum_d;
  logic          sum_sign_d;

  always_comb begin
    if (al_sub_q) sum_d = {1'b0, big_q} - {1'b0, small_q};
    else          sum_d = {1'b0, big_q} + {1'b0, small_q};
    sum_sign_d = (al_sub_q && (sum_d == '0)) ? 1'b0 : al_sign_q;
  end

  // normalize
  int                   lz;
  logic signed [ew-1:0] nexp0, nexp_d;
  logic [wide-1:0]      nrm_d;
  logic                 zero_d, uf_d;

  always_comb begin
    lz = wide;
    for (int i = 0; i < wide; i++)
      if (sum_q[i]) lz = wide - 1 - i;
    nexp0  = {2'b00, sum_exp_q};
    nexp_d = nexp0;
    nrm_d  = '0;
    zero_d = 1'b0;
    uf_d   = 1'b0;
    if (sum_q[wide]) begin
      nrm_d  = {sum_q[wide:2], sum_q[1] | sum_q[0]};
      nexp_d = nexp0 + ew'(1);
    end else if (sum_q == '0) begin
      zero_d = 1'b1;
    end else begin
      nexp_d = nexp0 - ew'(lz);
      if (nexp_d[ew-1] || (nexp_d == '0)) begin
        zero_d = 1'b1;
        uf_d   = 1'b1;
      end else begin
        nrm_d = sum_q[wide-1:0] << lz;
      end
    end
  end

  // pack
  logic [man_w-1:0]     mant;
  logic [man_w:0]       mant_r;
  logic                 g_bit, r_bit, s_bit, rnd_up;
  logic signed [ew-1:0] pexp;
  logic [frac_bits-1:0] pfrac;
  logic [bitness-1:0]   pack_res;
  logic [3:0]           pack_flags;

  always_comb begin
    mant   = nrm_q[wide-1:3];
    g_bit  = nrm_q[2];
    r_bit  = nrm_q[1];
    s_bit  = nrm_q[0];
    rnd_up = g_bit & (r_bit | s_bit | mant[0]);
    mant_r = {1'b0, mant} + (man_w+1)'(rnd_up);
    pexp   = nexp_q + ew'(mant_r[man_w]);
    pfrac  = mant_r[man_w] ? mant_r[frac_bits:1] : mant_r[frac_bits-1:0];
    if (spec_q) begin
      pack_res   = spec_res_q;
      pack_flags = spec_flags_q;
    end else if (zero_q) begin
      pack_res   = {nsign_q, {(bitness-1){1'b0}}};
      pack_flags = {2'b00, uf_q, uf_q};
    end else if (pexp >= exp_max) begin
      pack_res   = {nsign_q, exp_ones, {frac_bits{1'b0}}};
      pack_flags = 4'b0101;
    end else begin
      pack_res   = {nsign_q, pexp[exp_bits-1:0], pfrac};
      pack_flags = {3'b000, g_bit | r_bit | s_bit};
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      a_q  <= a;
      b_q  <= b;
      op_q <= op;
    end
    if (state == S_UNPACK) begin
      sa_q <= sa_d;  sb_q <= sb_d;
      ea_q <= ea_d;  eb_q <= eb_d;
      ma_q <= ma_d;  mb_q <= mb_d;
      spec_q       <= spec_d;
      spec_res_q   <= spec_res_d;
      spec_flags_q <= spec_flags_d;
    end
    if (state == S_ALIGN) begin
      al_sign_q <= al_sign_d;
      al_sub_q  <= sa_q ^ sb_q;
      al_exp_q  <= e_big;
      big_q     <= {m_big, 3'b000};
      small_q   <= small_d;
    end
    if (state == S_ADD) begin
      sum_q      <= sum_d;
      sum_sign_q <= sum_sign_d;
      sum_exp_q  <= al_exp_q;
    end
    if (state == S_NORM) begin
      nrm_q   <= nrm_d;
      nexp_q  <= nexp_d;
      nsign_q <= sum_sign_q;
      zero_q  <= zero_d;
      uf_q    <= uf_d;
    end
  end

  // DONE spends its first cycle raising out_valid so the offered result is already in flops
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_PACK) begin
        result <= pack_res;
        flags  <= pack_flags;
      end
      if (state == S_DONE) out_valid <= !(out_valid && out_ready);
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_UNPACK;
      end
      S_UNPACK: state_nxt = S_ALIGN;
      S_ALIGN:  state_nxt = S_ADD;
      S_ADD:    state_nxt = S_NORM;
      S_NORM:   state_nxt = S_PACK;
      S_PACK:   state_nxt = S_DONE;
      S_DONE:   if (out_valid && out_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fpu_addsub_seq.sv
// Directed bench for fpu_addsub_seq: double-precision vector table plus
// single-precision stall and mid-operation reset sequences.
module tb_fpu_addsub_seq;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        iv64 = 0, ir64, op64 = 0, ov64, or64 = 1;
  logic [63:0] a64 = '0, b64 = '0, res64;
  logic [3:0]  fl64;
  logic        iv32 = 0, ir32, op32 = 0, ov32, or32 = 1;
  logic [31:0] a32 = '0, b32 = '0, res32;
  logic [3:0]  fl32;

  fpu_addsub_seq #(.bitness(64), .exp_bits(11), .frac_bits(52)) dut64 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv64), .in_ready(ir64),
    .a(a64), .b(b64), .op(op64), .out_valid(ov64), .out_ready(or64),
    .result(res64), .flags(fl64));

  fpu_addsub_seq #(.bitness(32), .exp_bits(8), .frac_bits(23)) dut32 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv32), .in_ready(ir32),
    .a(a32), .b(b32), .op(op32), .out_valid(ov32), .out_ready(or32),
    .result(res32), .flags(fl32));

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       name;
    logic [63:0] a, b;
    logic        op;
    logic [63:0] res;
    logic [3:0]  flg;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string n, input logic [63:0] a, input logic [63:0] b,
                         input logic op, input logic [63:0] res, input logic [3:0] flg);
    vec_t v;
    v.name = n; v.a = a; v.b = b; v.op = op; v.res = res; v.flg = flg;
    vecs.push_back(v);
  endtask

  function automatic logic get_ov(input bit w32);
    return w32 ? ov32 : ov64;
  endfunction
  function automatic logic get_ir(input bit w32);
    return w32 ? ir32 : ir64;
  endfunction
  function automatic logic [63:0] get_res(input bit w32);
    return w32 ? {32'h0, res32} : res64;
  endfunction
  function automatic logic [3:0] get_fl(input bit w32);
    return w32 ? fl32 : fl64;
  endfunction

  // One full transaction; hold>0 keeps out_ready low for that many cycles after out_valid.
  task automatic run_op(input string name, input bit w32, input logic [63:0] a,
                        input logic [63:0] b, input logic op, input logic [63:0] exp_res,
                        input logic [3:0] exp_fl, input int hold);
    int  n;
    bit  busy_ok, stable_ok;
    @(negedge clk);
    if (w32) begin iv32 = 1; a32 = a[31:0]; b32 = b[31:0]; op32 = op; or32 = (hold == 0); end
    else     begin iv64 = 1; a64 = a;       b64 = b;       op64 = op; or64 = (hold == 0); end
    check({name, ".in_ready_idle"}, 64'(get_ir(w32)), 64'd1);
    @(negedge clk);
    iv32 = 0; iv64 = 0;
    n = 0;
    busy_ok = 1;
    while (!get_ov(w32) && n < 20) begin
      if (get_ir(w32)) busy_ok = 0;
      @(negedge clk);
      n++;
    end
    check({name, ".latency"}, 64'(n), 64'd6);
    check({name, ".in_ready_busy"}, 64'(busy_ok), 64'd1);
    check({name, ".result"}, get_res(w32), exp_res);
    check({name, ".flags"}, 64'(get_fl(w32)), 64'(exp_fl));
    if (hold > 0) begin
      stable_ok = 1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (!get_ov(w32) || get_res(w32) !== exp_res || get_fl(w32) !== exp_fl || get_ir(w32))
          stable_ok = 0;
      end
      check({name, ".stall_stable"}, 64'(stable_ok), 64'd1);
      if (w32) or32 = 1; else or64 = 1;
    end
    @(negedge clk);
    check({name, ".out_valid_drop"}, 64'(get_ov(w32)), 64'd0);
    check({name, ".in_ready_back"}, 64'(get_ir(w32)), 64'd1);
  endtask

  initial begin
    bit stale;
    add_vec("add_1_2",       64'h3FF0000000000000, 64'h4000000000000000, 0, 64'h4008000000000000, 4'b0000);
    add_vec("sub_eq_zero",   64'h3FF0000000000000, 64'h3FF0000000000000, 1, 64'h0000000000000000, 4'b0000);
    add_vec("inf_minus_inf", 64'h7FF0000000000000, 64'hFFF0000000000000, 0, 64'h7FF8000000000000, 4'b1000);
    add_vec("inf_sub_inf",   64'h7FF0000000000000, 64'h7FF0000000000000, 1, 64'h7FF8000000000000, 4'b1000);
    add_vec("overflow",      64'h7FEFFFFFFFFFFFFF, 64'h7FEFFFFFFFFFFFFF, 0, 64'h7FF0000000000000, 4'b0101);
    add_vec("tie_even_down", 64'h3FF0000000000000, 64'h3CA0000000000000, 0, 64'h3FF0000000000000, 4'b0001);
    add_vec("tie_even_up",   64'h3FF0000000000001, 64'h3CA0000000000000, 0, 64'h3FF0000000000002, 4'b0001);
    add_vec("above_half",    64'h3FF0000000000000, 64'h3CA0000000000001, 0, 64'h3FF0000000000001, 4'b0001);
    add_vec("nan_in",        64'h7FF0000000000001, 64'h3FF0000000000000, 0, 64'h7FF8000000000000, 4'b0000);
    add_vec("inf_plus_fin",  64'h7FF0000000000000, 64'h3FF0000000000000, 0, 64'h7FF0000000000000, 4'b0000);
    add_vec("ninf_plus_fin", 64'hFFF0000000000000, 64'h4000000000000000, 0, 64'hFFF0000000000000, 4'b0000);
    add_vec("negz_plus_negz",64'h8000000000000000, 64'h8000000000000000, 0, 64'h8000000000000000, 4'b0000);
    add_vec("negz_sub_posz", 64'h8000000000000000, 64'h0000000000000000, 1, 64'h8000000000000000, 4'b0000);
    add_vec("sub_3_1",       64'h4008000000000000, 64'h3FF0000000000000, 1, 64'h4000000000000000, 4'b0000);
    add_vec("sub_1_3",       64'h3FF0000000000000, 64'h4008000000000000, 1, 64'hC000000000000000, 4'b0000);
    add_vec("sub_lzc2",      64'h3FF0000000000000, 64'h3FE8000000000000, 1, 64'h3FD0000000000000, 4'b0000);
    add_vec("borrow_round",  64'h3FF0000000000000, 64'h3C90000000000000, 1, 64'h3FF0000000000000, 4'b0001);
    add_vec("far_shift",     64'h3FF0000000000000, 64'h39B0000000000000, 0, 64'h3FF0000000000000, 4'b0001);
    add_vec("denorm_flush",  64'h0000000000000001, 64'h3FF0000000000000, 0, 64'h3FF0000000000000, 4'b0000);
    add_vec("underflow",     64'h0010000000000000, 64'h0010000000000001, 1, 64'h8000000000000000, 4'b0011);

    repeat (3) @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    check("rst.in_ready64",  64'(ir64), 64'd1);
    check("rst.out_valid64", 64'(ov64), 64'd0);
    check("rst.result64",    res64, 64'd0);
    check("rst.flags64",     64'(fl64), 64'd0);
    check("rst.in_ready32",  64'(ir32), 64'd1);
    check("rst.out_valid32", 64'(ov32), 64'd0);

    foreach (vecs[i])
      run_op(vecs[i].name, 0, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].flg, 0);

    run_op("sp_add", 1, 64'h3FC00000, 64'h40100000, 0, 64'h40700000, 4'b0000, 0);
    run_op("sp_stall", 1, 64'h3FC00000, 64'h40100000, 0, 64'h40700000, 4'b0000, 5);

    // Abort 1.0+1.0 with a reset while it sits in ALIGN.
    @(negedge clk);
    iv64 = 1; a64 = 64'h3FF0000000000000; b64 = 64'h3FF0000000000000; op64 = 0; or64 = 1;
    @(negedge clk);
    iv64 = 0;
    @(negedge clk);
    reset_n = 0;
    @(negedge clk);
    reset_n = 1;
    check("abort.in_ready",  64'(ir64), 64'd1);
    check("abort.out_valid", 64'(ov64), 64'd0);
    check("abort.result",    res64, 64'd0);
    stale = 0;
    repeat (10) begin
      @(negedge clk);
      if (ov64) stale = 1;
    end
    check("abort.no_stale", 64'(stale), 64'd0);
    run_op("after_abort", 0, 64'h3FF0000000000000, 64'h4000000000000000, 0,
           64'h4008000000000000, 4'b0000, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fpu_addsub_seq.md
Name: fpu_addsub_seq

Overview:
Multi-cycle IEEE-754 binary floating-point adder/subtractor with a valid/ready handshake on both sides. It is a parametrised successor to the combinational FPU skeleton: the format is set by exponent and fraction widths, and the unit adds a real unpack/align/add/normalize/pack state machine, round-to-nearest-even, special-value handling and exception flags. It sits between the issue logic and the FP register-file writeback.

Parameters:
bitness, 64, total operand width; must equal 1+exp_bits+frac_bits.
exp_bits, 11, exponent field width (5/8/11/15 supported).
frac_bits, 52, stored fraction width (10/23/52/112 supported).

Ports:
clk  input  1  clock, rising edge.
reset_n  input  1  synchronous active-low reset.
in_valid  input  1  operands and op are valid.
in_ready  output  1  unit can accept an operation.
a  input  bitness  first operand.
b  input  bitness  second operand.
op  input  1  0 = a+b, 1 = a-b.
out_valid  output  1  result and flags are valid.
out_ready  input  1  consumer takes the result.
result  output  bitness  packed IEEE result.
flags  output  4  {invalid, overflow, underflow, inexact}.

Behaviour:
- Reset (reset_n low at a clk edge): state=IDLE, in_ready=1, out_valid=0, result=0, flags=0. Any in-flight operation is discarded, and no result is ever produced for it.
- FSM: IDLE -> UNPACK -> ALIGN -> ADD -> NORMALIZE -> PACK -> DONE -> IDLE. One state per cycle. The only stall is in DONE.
- IDLE: in_ready=1. When in_valid&&in_ready at an edge, a, b and op are registered and the FSM moves to UNPACK. in_ready=0 in every other state. There is no overlap of operations.
- UNPACK: split sign, exponent and fraction. For subtraction, b's sign is inverted. A nonzero exponent gets the hidden bit 1. Denormal inputs (exp=0) are flushed to signed zero.
- Specials are resolved in UNPACK and bypass the datapath. The FSM still steps through every state, so latency stays fixed.
  - Any NaN operand -> canonical quiet NaN: sign 0, exp all ones, fraction MSB 1, rest 0. No flag is raised.
  - +inf + -inf (after op sign inversion) -> canonical NaN with invalid=1.
  - inf with a finite operand -> that inf.
  - Zero + zero -> +0, except -0 + -0 -> -0.
- ALIGN: swap so the larger magnitude is first. Right-shift the smaller mantissa by the exponent difference, keeping guard, round and sticky bits. The sticky bit ORs all bits shifted out. A shift of frac_bits+3 or more leaves only the sticky bit.
- ADD: equal signs add magnitudes (carry bit kept). Different signs subtract smaller from larger. The result sign is the sign of the larger operand. An exact zero difference gives +0.
- NORMALIZE:
  - On carry, right-shift by 1 and increment the exponent; the shifted-out bit folds into sticky.
  - Otherwise, left-shift by the leading-zero count (single cycle) and decrement the exponent.
  - If the exponent would go ≤0, the result is flushed to signed zero with underflow=1 and inexact=1.
- PACK:
  - Round to nearest, ties to even, using guard/round/sticky.
  - A rounding carry out of the mantissa increments the exponent.
  - An exponent ≥ all-ones gives a signed inf with overflow=1 and inexact=1.
  - inexact=1 whenever any of guard/round/sticky is nonzero.
- DONE: out_valid=1, and result and flags are held stable. At the edge where out_ready=1, out_valid drops and the FSM returns to IDLE. in_ready rises the cycle after.
- Latency: the operation is accepted at edge k. out_valid is high after edge k+6 and stays high until out_ready. Maximum throughput is one operation per 8 cycles with out_ready tied high.
- in_valid in any non-IDLE state is ignored. The upstream block must hold it until in_ready.

Test Plan:
- bitness=64: a=0x3FF0000000000000 (1.0), b=0x4000000000000000, op=0 -> result=0x4008000000000000, flags=0, out_valid 6 edges after accept.
- a=b=0x3FF0000000000000, op=1 -> result=0x0000000000000000 (+0), flags=0. a=0x7FF0000000000000, b=0xFFF0000000000000, op=0 -> 0x7FF8000000000000, flags=4'b1000.
- a=b=0x7FEFFFFFFFFFFFFF, op=0 -> 0x7FF0000000000000, flags=4'b0101. a=0x3FF0000000000000, b=0x3CA0000000000000 (2^-53 tie), op=0 -> 0x3FF0000000000000, flags=4'b0001.
- bitness=32, exp_bits=8, frac_bits=23: a=0x3FC00000, b=0x40100000, op=0 -> 0x40700000, flags=0. out_ready held low 5 cycles -> out_valid and result stable, in_ready=0 throughout.
- Accept an operation, drive reset_n low in the ALIGN state for one edge -> state=IDLE, out_valid=0, in_ready=1 next cycle. A following 1.0+2.0 returns 0x4008000000000000 and no stale result appears.
